// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between gate_truth_checker and its host plus gate under test.
// err_cnt is present only when GATE_CHECK_ERRCNT_EN is defined.
interface gate_truth_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic            fail;
    logic [N_IN-1:0] fail_vec;
    logic            fail_got;
`ifdef GATE_CHECK_ERRCNT_EN
    logic [N_IN:0]   err_cnt;

    modport master (
        output start, gate_out,
        input  gate_in, busy, done, pass, fail, fail_vec, fail_got, err_cnt
    );

    modport slave (
        input  start, gate_out,
        output gate_in, busy, done, pass, fail, fail_vec, fail_got, err_cnt
    );
`else
    modport master (
        output start, gate_out,
        input  gate_in, busy, done, pass, fail, fail_vec, fail_got
    );

    modport slave (
        input  start, gate_out,
        output gate_in, busy, done, pass, fail, fail_vec, fail_got
    );
`endif
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector onto a small combinational gate and checks its output
// against a truth table. Optional mismatch counter: define GATE_CHECK_ERRCNT_EN.
module gate_truth_checker #(
    parameter int unsigned        N_IN       = 2,
    parameter logic [2**N_IN-1:0] EXPECTED   = 4'b1110,
    parameter int unsigned        SETTLE_CYC = 2
) (
    input logic                 clk,
    input logic                 rst,
    gate_truth_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);

    state_t          state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [N_IN-1:0] vec, vec_n;
    logic [N_IN-1:0] fvec, fvec_n;
    logic            fgot, fgot_n;
    logic            fail_r, fail_n;
    logic            pass_r, pass_n;
    logic            mismatch;
    logic            last_vec;

`ifdef GATE_CHECK_ERRCNT_EN
    localparam logic [N_IN:0] ERR_ONE = (N_IN + 1)'(1);
    logic [N_IN:0] err, err_n;
`endif

    assign mismatch = (bus.gate_out != EXPECTED[vec]);
    assign last_vec = (vec == '1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        fvec_n  = fvec;
        fgot_n  = fgot;
        fail_n  = fail_r;
        pass_n  = pass_r;
`ifdef GATE_CHECK_ERRCNT_EN
        err_n   = err;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    vec_n   = '0;
                    fvec_n  = '0;
                    fgot_n  = 1'b0;
                    fail_n  = 1'b0;
                    pass_n  = 1'b0;
`ifdef GATE_CHECK_ERRCNT_EN
                    err_n   = '0;
`endif
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            SAMPLE: begin
                // only the first mismatch of a sweep is recorded
                if (mismatch && !fail_r) begin
                    fail_n = 1'b1;
                    fvec_n = vec;
                    fgot_n = bus.gate_out;
                end
`ifdef GATE_CHECK_ERRCNT_EN
                if (mismatch) begin
                    err_n = err + ERR_ONE;
                end
`endif
                if (last_vec) begin
                    state_n = DONE;
                    pass_n  = !(fail_r || mismatch);
                end else begin
                    state_n = SETTLE;
                    vec_n   = vec + VEC_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            vec    <= '0;
            fvec   <= '0;
            fgot   <= 1'b0;
            fail_r <= 1'b0;
            pass_r <= 1'b0;
`ifdef GATE_CHECK_ERRCNT_EN
            err    <= '0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            vec    <= vec_n;
            fvec   <= fvec_n;
            fgot   <= fgot_n;
            fail_r <= fail_n;
            pass_r <= pass_n;
`ifdef GATE_CHECK_ERRCNT_EN
            err    <= err_n;
`endif
        end
    end

    assign bus.gate_in  = vec;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.pass     = pass_r;
    assign bus.fail     = fail_r;
    assign bus.fail_vec = fvec;
    assign bus.fail_got = fgot;
`ifdef GATE_CHECK_ERRCNT_EN
    assign bus.err_cnt  = err;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a 2-input default instance and a 3-input OR instance,
// driven by a behavioural gate whose truth table the bench chooses per sweep.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst;
    logic start_req;
    logic sel;          // 0 = 2-input instance, 1 = 3-input instance
    logic [7:0] tt;     // truth table of the gate under test

    always #5 clk = ~clk;

    gate_truth_checker_if #(.N_IN(2)) bus_a ();
    gate_truth_checker_if #(.N_IN(3)) bus_b ();

    assign bus_a.start    = start_req & ~sel;
    assign bus_b.start    = start_req & sel;
    assign bus_a.gate_out = tt[bus_a.gate_in];
    assign bus_b.gate_out = tt[bus_b.gate_in];

    gate_truth_checker dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    gate_truth_checker #(
        .N_IN       (3),
        .EXPECTED   (8'b11111110),
        .SETTLE_CYC (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [31:0] obs_busy, obs_done, obs_pass, obs_fail, obs_vec, obs_got, obs_gin, obs_err;

    always_comb begin
        obs_err = '0;
        if (sel) begin
            obs_busy = 32'(bus_b.busy);
            obs_done = 32'(bus_b.done);
            obs_pass = 32'(bus_b.pass);
            obs_fail = 32'(bus_b.fail);
            obs_vec  = 32'(bus_b.fail_vec);
            obs_got  = 32'(bus_b.fail_got);
            obs_gin  = 32'(bus_b.gate_in);
`ifdef GATE_CHECK_ERRCNT_EN
            obs_err  = 32'(bus_b.err_cnt);
`endif
        end else begin
            obs_busy = 32'(bus_a.busy);
            obs_done = 32'(bus_a.done);
            obs_pass = 32'(bus_a.pass);
            obs_fail = 32'(bus_a.fail);
            obs_vec  = 32'(bus_a.fail_vec);
            obs_got  = 32'(bus_a.fail_got);
            obs_gin  = 32'(bus_a.gate_in);
`ifdef GATE_CHECK_ERRCNT_EN
            obs_err  = 32'(bus_a.err_cnt);
`endif
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: walk the truth tables directly.
    function automatic void model(input int nin, input logic [7:0] expct, input logic [7:0] gate_tt,
                                  output logic p, output int fv, output logic fg, output int cnt);
        p = 1'b1; fv = 0; fg = 1'b0; cnt = 0;
        for (int i = 0; i < (1 << nin); i++) begin
            if (gate_tt[i] !== expct[i]) begin
                if (p) begin
                    fv = i;
                    fg = gate_tt[i];
                end
                p = 1'b0;
                cnt++;
            end
        end
    endfunction

    // One full sweep. Cycle n=1 is the first cycle after the accepted start edge;
    // done is due at n = 1 + vectors*(settle+1). cont=1 chains directly from a previous sweep.
    task automatic sweep(input logic which, input logic [7:0] gate_tt, input logic ep, input int ev,
                         input logic eg, input int ee, input bit poke, input bit cont);
        int nin = which ? 3 : 2;
        int s   = which ? 1 : 2;
        int nv  = 1 << nin;
        int len = 1 + nv * (s + 1);
        int v;
        if (!cont) @(negedge clk);
        sel       = which;
        tt        = gate_tt;
        start_req = 1'b1;
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            start_req = poke && (n == 2 || n == 7 || n == len);
            v = (n - 1) / (s + 1);
            if (v > nv - 1) v = nv - 1;
            check("busy", obs_busy, 32'(n <= len));
            check("done", obs_done, 32'(n == len));
            check("gate_in", obs_gin, 32'(v));
            if (n >= len) begin
                check("pass", obs_pass, 32'(ep));
                check("fail", obs_fail, 32'(!ep));
                check("fail_vec", obs_vec, 32'(ev));
                check("fail_got", obs_got, 32'(eg));
`ifdef GATE_CHECK_ERRCNT_EN
                check("err_cnt", obs_err, 32'(ee));
`else
                if (ee < 0) check("err_cnt_arg", 32'(ee), 32'(0));
`endif
            end
        end
    endtask

    typedef struct {
        logic       which;
        logic [7:0] gate_tt;
        logic       ep;
        int         ev;
        logic       eg;
        int         ee;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic p;
        int   fv, cnt;
        logic fg;
        logic w;
        logic [7:0] rt;

        tbl[0] = '{1'b0, 8'h0E, 1'b1, 0, 1'b0, 0};  // correct OR
        tbl[1] = '{1'b0, 8'h08, 1'b0, 1, 1'b0, 2};  // AND
        tbl[2] = '{1'b0, 8'h0F, 1'b0, 0, 1'b1, 1};  // stuck at 1
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 3};  // stuck at 0
        tbl[4] = '{1'b0, 8'h06, 1'b0, 3, 1'b0, 1};  // XOR
        tbl[5] = '{1'b0, 8'h01, 1'b0, 0, 1'b1, 4};  // NOR, every vector wrong
        tbl[6] = '{1'b1, 8'hFE, 1'b1, 0, 1'b0, 0};  // 3-input OR
        tbl[7] = '{1'b1, 8'h80, 1'b0, 1, 1'b0, 6};  // 3-input AND

        rst = 1'b1; start_req = 1'b0; sel = 1'b0; tt = 8'h0E;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_a.busy), 0);
        check("rst_done", 32'(bus_a.done), 0);
        check("rst_pass", 32'(bus_a.pass), 0);
        check("rst_fail", 32'(bus_a.fail), 0);
        check("rst_gate_in", 32'(bus_a.gate_in), 0);
        check("rst_fail_vec", 32'(bus_a.fail_vec), 0);
        check("rst_fail_got", 32'(bus_a.fail_got), 0);
        check("rst_b_busy", 32'(bus_b.busy), 0);
        check("rst_b_gate_in", 32'(bus_b.gate_in), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            sweep(tbl[i].which, tbl[i].gate_tt, tbl[i].ep, tbl[i].ev, tbl[i].eg, tbl[i].ee, 1'b0, 1'b0);

        // starts during SETTLE/SAMPLE/DONE must be ignored
        sweep(1'b0, 8'h0E, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);

        // back-to-back: start in the IDLE cycle right after DONE
        sweep(1'b0, 8'h0F, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        sweep(1'b0, 8'h0E, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);

        // reset mid-sweep after a mismatch has been recorded
        @(negedge clk);
        sel = 1'b0; tt = 8'h0F; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_fail", 32'(bus_a.fail), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus_a.busy), 0);
        check("mid_rst_gate_in", 32'(bus_a.gate_in), 0);
        check("mid_rst_pass", 32'(bus_a.pass), 0);
        check("mid_rst_fail", 32'(bus_a.fail), 0);
        start_req = 1'b1;  // rst and start together: rst wins
        @(negedge clk);
        check("rst_start_busy", 32'(bus_a.busy), 0);
        rst = 1'b0; start_req = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            check("post_rst_done", 32'(bus_a.done), 0);
        end
        sweep(1'b0, 8'h0E, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);

        // random gates against the reference model
        for (int r = 0; r < 12; r++) begin
            w  = 1'($urandom_range(0, 1));
            rt = 8'($urandom);
            if (w) model(3, 8'hFE, rt, p, fv, fg, cnt);
            else   model(2, 8'h0E, rt, p, fv, fg, cnt);
            sweep(w, rt, p, fv, fg, cnt, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
